// File: rtl/l2_cache_tag_lru_pkg.sv
// Shared definitions for the L2 tag/LRU array: geometry, op encoding, response record.
package cache_def;

  localparam int WAYS      = 4;
  localparam int DEPTH_L2  = 1024;
  localparam int TAG_W     = 18;
  localparam int INDEX_L2  = $clog2(DEPTH_L2);
  localparam int INDEX_WAY = $clog2(WAYS);

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_FILL   = 1'b1
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Age per way; age 0 is MRU, age WAYS-1 is LRU.
  typedef logic [WAYS-1:0][INDEX_WAY-1:0] ages_t;

  typedef struct packed {
    logic                 hit;
    logic [INDEX_WAY-1:0] way;
    logic                 evict_valid;
    logic                 evict_dirty;
    logic [TAG_W-1:0]     evict_tag;
  } resp_t;

  function automatic ages_t init_ages();
    ages_t a;
    for (int w = 0; w < WAYS; w++) begin
      a[w] = INDEX_WAY'(w);
    end
    return a;
  endfunction

endpackage

// File: rtl/l2_cache_tag_lru_lru_age_update.sv
// True-LRU age update for one set: touched way goes to age 0, younger ways age by one.
module lru_age_update
  import cache_def::*;
(
  input  ages_t                ages_i,
  input  logic [INDEX_WAY-1:0] touch_way_i,
  output ages_t                ages_o,
  output logic [INDEX_WAY-1:0] oldest_way_o
);

  logic [INDEX_WAY-1:0] touched_age;

  assign touched_age = ages_i[touch_way_i];

  always_comb begin
    ages_o = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (touch_way_i == INDEX_WAY'(w)) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < touched_age) begin
        ages_o[w] = ages_i[w] + INDEX_WAY'(1);
      end
    end
  end

  // Kept in its own process: the victim choice feeds touch_way_i back in.
  always_comb begin
    oldest_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_i[w] == INDEX_WAY'(WAYS - 1)) begin
        oldest_way_o = INDEX_WAY'(w);
      end
    end
  end

endmodule

// File: rtl/l2_cache_tag_lru.sv
// L2 tag/valid/dirty/LRU array with hit resolution, victim selection and registered response.
// Optional hit/miss statistics counters are built when L2_TAG_STATS_EN is defined.
module l2_cache_tag_lru
  import cache_def::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 ready_o,
  input  logic                 req_op_i,
  input  logic                 req_write_i,
  input  logic [INDEX_L2-1:0]  req_index_i,
  input  logic [TAG_W-1:0]     req_tag_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [INDEX_WAY-1:0] resp_way_o,
  output logic [INDEX_WAY-1:0] address_way_tag2data_o,
  output logic                 evict_valid_o,
  output logic                 evict_dirty_o,
  output logic [TAG_W-1:0]     evict_tag_o,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  state_e              state_q, state_d;
  logic [INDEX_L2-1:0] sweep_q, sweep_d;

  logic [WAYS-1:0][TAG_W-1:0] tag_mem   [DEPTH_L2];
  logic [WAYS-1:0]            valid_mem [DEPTH_L2];
  logic [WAYS-1:0]            dirty_mem [DEPTH_L2];
  ages_t                      age_mem   [DEPTH_L2];

  logic [WAYS-1:0][TAG_W-1:0] rd_tag;
  logic [WAYS-1:0]            rd_valid;
  logic [WAYS-1:0]            rd_dirty;
  ages_t                      rd_ages;
  ages_t                      new_ages;

  logic                 accept;
  logic                 is_fill;
  logic                 hit;
  logic [INDEX_WAY-1:0] hit_way;
  logic [INDEX_WAY-1:0] oldest_way;
  logic [INDEX_WAY-1:0] victim_way;
  logic [INDEX_WAY-1:0] touch_way;
  logic                 fill_miss;
  logic                 do_write;

  resp_t resp_d, resp_q;
  logic  resp_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + INDEX_L2'(1);
        if (sweep_q == INDEX_L2'(DEPTH_L2 - 1)) begin
          state_d = ST_IDLE;
          sweep_d = '0;
        end
      end
      ST_IDLE: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  assign accept   = req_valid_i && ready_o;
  assign is_fill  = (req_op_i == OP_FILL);
  assign rd_tag   = tag_mem[req_index_i];
  assign rd_valid = valid_mem[req_index_i];
  assign rd_dirty = dirty_mem[req_index_i];
  assign rd_ages  = age_mem[req_index_i];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && (rd_tag[w] == req_tag_i)) begin
        hit     = 1'b1;
        hit_way = INDEX_WAY'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; LRU way only when the set is full.
  always_comb begin
    victim_way = oldest_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) begin
        victim_way = INDEX_WAY'(w);
      end
    end
  end

  assign touch_way = hit ? hit_way : victim_way;
  assign fill_miss = is_fill && !hit;
  assign do_write  = accept && (hit || is_fill);

  lru_age_update u_lru (
    .ages_i       (rd_ages),
    .touch_way_i  (touch_way),
    .ages_o       (new_ages),
    .oldest_way_o (oldest_way)
  );

  // Array storage has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      tag_mem[sweep_q]   <= '0;
      valid_mem[sweep_q] <= '0;
      dirty_mem[sweep_q] <= '0;
      age_mem[sweep_q]   <= init_ages();
    end else if (do_write) begin
      age_mem[req_index_i] <= new_ages;
      if (hit) begin
        dirty_mem[req_index_i][hit_way] <= rd_dirty[hit_way] | req_write_i;
      end else begin
        tag_mem[req_index_i][victim_way]   <= req_tag_i;
        valid_mem[req_index_i][victim_way] <= 1'b1;
        dirty_mem[req_index_i][victim_way] <= req_write_i;
      end
    end
  end

  always_comb begin
    resp_d             = '0;
    resp_d.hit         = hit;
    resp_d.way         = touch_way;
    resp_d.evict_valid = fill_miss && rd_valid[victim_way];
    resp_d.evict_dirty = fill_miss && rd_dirty[victim_way];
    resp_d.evict_tag   = fill_miss ? rd_tag[victim_way] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_q <= resp_d;
      end
    end
  end

  assign resp_valid_o           = resp_valid_q;
  assign resp_hit_o             = resp_q.hit;
  assign resp_way_o             = resp_q.way;
  assign address_way_tag2data_o = resp_q.way;
  assign evict_valid_o          = resp_q.evict_valid;
  assign evict_dirty_o          = resp_q.evict_dirty;
  assign evict_tag_o            = resp_q.evict_tag;

`ifdef L2_TAG_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept && !is_fill) begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2_cache_tag_lru.sv
// Bench for l2_cache_tag_lru: directed vector table, recency-list reference model, reset/INIT checks.
module tb_l2_cache_tag_lru;
  import cache_def::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic                 ready_o;
  logic                 req_op_i = 1'b0;
  logic                 req_write_i = 1'b0;
  logic [INDEX_L2-1:0]  req_index_i = '0;
  logic [TAG_W-1:0]     req_tag_i = '0;
  logic                 resp_valid_o;
  logic                 resp_hit_o;
  logic [INDEX_WAY-1:0] resp_way_o;
  logic [INDEX_WAY-1:0] address_way_tag2data_o;
  logic                 evict_valid_o;
  logic                 evict_dirty_o;
  logic [TAG_W-1:0]     evict_tag_o;
  logic [31:0]          hit_cnt_o;
  logic [31:0]          miss_cnt_o;

  l2_cache_tag_lru dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .req_valid_i            (req_valid_i),
    .ready_o                (ready_o),
    .req_op_i               (req_op_i),
    .req_write_i            (req_write_i),
    .req_index_i            (req_index_i),
    .req_tag_i              (req_tag_i),
    .resp_valid_o           (resp_valid_o),
    .resp_hit_o             (resp_hit_o),
    .resp_way_o             (resp_way_o),
    .address_way_tag2data_o (address_way_tag2data_o),
    .evict_valid_o          (evict_valid_o),
    .evict_dirty_o          (evict_dirty_o),
    .evict_tag_o            (evict_tag_o),
    .hit_cnt_o              (hit_cnt_o),
    .miss_cnt_o             (miss_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit               hit;
    int               way;
    bit               ev_v;
    bit               ev_d;
    logic [TAG_W-1:0] ev_t;
  } exp_t;

  typedef struct {
    bit               op;
    bit               wr;
    logic [INDEX_L2-1:0] idx;
    logic [TAG_W-1:0] tag;
    exp_t             e;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // ---------------- reference model ----------------
  // Only a few sets are exercised; each keeps a recency list (position 0 = MRU).
  localparam int NSLOT = 5;
  logic [INDEX_L2-1:0] idx_tab [NSLOT] = '{10'd0, 10'd1, 10'd5, 10'd7, 10'd1023};
  bit               m_v   [NSLOT][WAYS];
  bit               m_d   [NSLOT][WAYS];
  logic [TAG_W-1:0] m_t   [NSLOT][WAYS];
  int               m_ord [NSLOT][WAYS];
  int               m_hits, m_miss;

  function automatic int slot_of(logic [INDEX_L2-1:0] idx);
    for (int s = 0; s < NSLOT; s++) if (idx_tab[s] == idx) return s;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NSLOT; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0; m_d[s][w] = 0; m_t[s][w] = '0; m_ord[s][w] = w;
      end
    end
    m_hits = 0; m_miss = 0;
  endfunction

  function automatic void model_touch(int s, int w);
    int p = 0;
    for (int k = 0; k < WAYS; k++) if (m_ord[s][k] == w) p = k;
    for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
    m_ord[s][0] = w;
  endfunction

  function automatic exp_t model_req(bit op, bit wr, logic [INDEX_L2-1:0] idx, logic [TAG_W-1:0] tag);
    exp_t e = '{0, 0, 0, 0, '0};
    int s = slot_of(idx);
    int hw = -1;
    int vw = -1;
    for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_t[s][w] == tag) hw = w;
    if (hw >= 0) begin
      e.hit = 1; e.way = hw;
      if (wr) m_d[s][hw] = 1;
      model_touch(s, hw);
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) vw = w;
      if (vw < 0) vw = m_ord[s][WAYS-1];
      e.way = vw;
      if (op) begin
        e.ev_v = m_v[s][vw]; e.ev_d = m_d[s][vw]; e.ev_t = m_t[s][vw];
        m_t[s][vw] = tag; m_v[s][vw] = 1; m_d[s][vw] = wr;
        model_touch(s, vw);
      end
    end
    if (!op) begin
      if (e.hit) m_hits++; else m_miss++;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_resp();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp_valid", 32'(resp_valid_o), 32'd1);
      chk("resp_hit", 32'(resp_hit_o), 32'(e.hit));
      chk("resp_way", 32'(resp_way_o), 32'(e.way));
      chk("way_to_data", 32'(address_way_tag2data_o), 32'(e.way));
      chk("evict_valid", 32'(evict_valid_o), 32'(e.ev_v));
      chk("evict_dirty", 32'(evict_dirty_o), 32'(e.ev_d));
      chk("evict_tag", 32'(evict_tag_o), 32'(e.ev_t));
    end else begin
      chk("resp_valid_idle", 32'(resp_valid_o), 32'd0);
    end
  endtask

  // One cycle: check last response, then drive this cycle's request.
  task automatic step(input bit vld, input bit op, input bit wr,
                      input logic [INDEX_L2-1:0] idx, input logic [TAG_W-1:0] tag,
                      input exp_t e);
    @(negedge clk_i);
    check_resp();
    req_valid_i = vld; req_op_i = op; req_write_i = wr;
    req_index_i = idx; req_tag_i = tag;
    if (vld) exp_q.push_back(e);
  endtask

  task automatic mstep(input bit op, input bit wr, input logic [INDEX_L2-1:0] idx,
                       input logic [TAG_W-1:0] tag);
    exp_t e = model_req(op, wr, idx, tag);
    step(1'b1, op, wr, idx, tag, e);
  endtask

  task automatic idle_step();
    exp_t e = '{0, 0, 0, 0, '0};
    step(1'b0, 1'b0, 1'b0, '0, '0, e);
  endtask

  // Called at the negedge where rst_i was dropped.
  task automatic wait_init(input string name);
    int n = 0;
    bit seen = 0;
    while (!ready_o && n < 5000) begin
      if (resp_valid_o) seen = 1;
      n++;
      @(negedge clk_i);
    end
    chk(name, 32'(n), 32'd1024);
    chk({name, "_no_resp"}, 32'(seen), 32'd0);
  endtask

  function automatic vec_t mk(int op, int wr, int idx, int tag, int hit, int way, int evv, int evd, int evt);
    vec_t v;
    v.op = (op != 0); v.wr = (wr != 0);
    v.idx = INDEX_L2'(idx); v.tag = TAG_W'(tag);
    v.e.hit = (hit != 0); v.e.way = way;
    v.e.ev_v = (evv != 0); v.e.ev_d = (evd != 0); v.e.ev_t = TAG_W'(evt);
    return v;
  endfunction

  vec_t vecs[25];

  // ---------------- test ----------------
  initial begin
    exp_t e;
    bit vld, op, wr;
    logic [INDEX_L2-1:0] idx;
    logic [TAG_W-1:0] tag;

    //         op wr idx   tag      hit way evv evd evt
    vecs[0]  = mk(0, 0, 5,    'h123,   0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 5,    'hA,     0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 5,    'hB,     0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 5,    'hC,     0, 2, 0, 0, 0);
    vecs[4]  = mk(1, 0, 5,    'hD,     0, 3, 0, 0, 0);
    vecs[5]  = mk(0, 0, 5,    'hA,     1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 5,    'hB,     1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 5,    'hC,     1, 2, 0, 0, 0);
    vecs[8]  = mk(0, 0, 5,    'hD,     1, 3, 0, 0, 0);
    vecs[9]  = mk(1, 1, 5,    'hE,     0, 0, 1, 0, 'hA);
    vecs[10] = mk(1, 0, 5,    'hF,     0, 1, 1, 0, 'hB);
    vecs[11] = mk(1, 0, 5,    'h10,    0, 2, 1, 1, 'hC);
    vecs[12] = mk(1, 0, 5,    'hE,     1, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 5,    'hE,     1, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 5,    'h11,    0, 3, 1, 0, 'hD);
    vecs[15] = mk(1, 0, 5,    'h12,    0, 1, 1, 0, 'hF);
    vecs[16] = mk(1, 0, 5,    'h13,    0, 2, 1, 0, 'h10);
    vecs[17] = mk(1, 0, 5,    'h14,    0, 0, 1, 1, 'hE);
    vecs[18] = mk(0, 0, 5,    'h99,    0, 3, 0, 0, 0);
    vecs[19] = mk(1, 0, 5,    'h1,     0, 3, 1, 0, 'h11);
    vecs[20] = mk(0, 0, 5,    'h1,     1, 3, 0, 0, 0);
    vecs[21] = mk(0, 0, 1023, 'h0,     0, 0, 0, 0, 0);
    vecs[22] = mk(1, 1, 1023, 'h3FFFF, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 1023, 'h3FFFF, 1, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0,    'h3FFFF, 0, 0, 0, 0, 0);

    model_reset();

    // Reset held: everything quiet.
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);

    // Request held during INIT must be ignored.
    req_valid_i = 1'b1; req_op_i = 1'b1; req_write_i = 1'b1;
    req_index_i = 10'd5; req_tag_i = 18'h123;
    rst_i = 1'b0;
    wait_init("init_len");
    req_valid_i = 1'b0;

    // Directed table, issued back to back.
    foreach (vecs[i]) begin
      e = model_req(vecs[i].op, vecs[i].wr, vecs[i].idx, vecs[i].tag);
      step(1'b1, vecs[i].op, vecs[i].wr, vecs[i].idx, vecs[i].tag, vecs[i].e);
    end
    idle_step();
    idle_step();
`ifdef L2_TAG_STATS_EN
    chk("tbl_hit_cnt", hit_cnt_o, 32'(m_hits));
    chk("tbl_miss_cnt", miss_cnt_o, 32'(m_miss));
`else
    chk("tbl_hit_cnt", hit_cnt_o, 32'd0);
    chk("tbl_miss_cnt", miss_cnt_o, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      op  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      idx = idx_tab[$urandom_range(0, NSLOT - 1)];
      tag = ($urandom_range(0, 15) == 0) ? TAG_W'($urandom_range(0, 262143))
                                         : TAG_W'($urandom_range(0, 11));
      if (vld) mstep(op, wr, idx, tag);
      else begin
        e = '{0, 0, 0, 0, '0};
        step(1'b0, op, wr, idx, tag, e);
      end
    end
    idle_step();
    idle_step();
`ifdef L2_TAG_STATS_EN
    chk("rnd_hit_cnt", hit_cnt_o, 32'(m_hits));
    chk("rnd_miss_cnt", miss_cnt_o, 32'(m_miss));
`endif

    // Reset just after an accepting edge drops the in-flight response.
    req_valid_i = 1'b1; req_op_i = 1'b0; req_write_i = 1'b0;
    req_index_i = 10'd5; req_tag_i = 18'h1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flight_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("flight_ready", 32'(ready_o), 32'd0);
    chk("flight_resp_hit", 32'(resp_hit_o), 32'd0);
    chk("flight_hit_cnt", hit_cnt_o, 32'd0);
    exp_q.delete();
    model_reset();
    rst_i = 1'b0;

    // Reset pulsed mid-INIT restarts the full sweep.
    repeat (300) @(negedge clk_i);
    chk("mid_init_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_init("init_len_restart");

    // Post-reset contents gone; 3 hits and 2 misses for the counters.
    mstep(1'b0, 1'b0, 10'd5, 18'h1);
    mstep(1'b1, 1'b0, 10'd5, 18'h20);
    mstep(1'b0, 1'b0, 10'd5, 18'h20);
    mstep(1'b0, 1'b1, 10'd5, 18'h20);
    mstep(1'b0, 1'b0, 10'd5, 18'h21);
    mstep(1'b0, 1'b0, 10'd5, 18'h20);
    idle_step();
    idle_step();
`ifdef L2_TAG_STATS_EN
    chk("stat_hit_cnt", hit_cnt_o, 32'd3);
    chk("stat_miss_cnt", miss_cnt_o, 32'd2);
`else
    chk("stat_hit_cnt", hit_cnt_o, 32'd0);
    chk("stat_miss_cnt", miss_cnt_o, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
